vga_frame_reader: RTL
=====================

Name: vga_frame_reader

Overview:
- Read side of the 320x240 RGB565 frame buffer that the camera capture path fills.
- Generates 640x480@60 VGA timing and fetches each buffer pixel for a 2x2 block of screen pixels (pixel and line doubling).
- Drives sync, data-enable and RGB565 to the display DAC/HDMI encoder, with all outputs aligned to the buffer read latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_W, 320, frame buffer width in pixels (= H_ACTIVE/2)
- FB_H, 240, frame buffer height in lines (= V_ACTIVE/2)
- RD_LATENCY, 1, clocks from rd_addr/rd_en sampled by the RAM to rd_data valid (legal: 1 or 2)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock (25.175/25 MHz)
- rst_n  in  1  asynchronous active-low reset
- rd_addr  out  17  frame buffer read address, 0..FB_W*FB_H-1
- rd_en  out  1  frame buffer read enable
- rd_data  in  16  RGB565 word from frame buffer, valid RD_LATENCY clocks after rd_addr/rd_en
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high on visible pixels
- red  out  5  rd_data[15:11] when de, else 0
- green  out  6  rd_data[10:5] when de, else 0
- blue  out  5  rd_data[4:0] when de, else 0
- frame_start  out  1  one-clock pulse coincident with first visible pixel (h=0, v=0) at the outputs

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800). v_cnt 0..V_TOTAL-1 (V_TOTAL = 525).
  - h_cnt wraps to 0 and v_cnt increments when h_cnt = H_TOTAL-1.
  - v_cnt wraps to 0 when both counters are at max.
- Stage 0 (counters): active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vs_raw = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
- Address generation is incremental; no multiplier.
  - Register line_base = (v_cnt>>1)*FB_W.
  - line_base resets to 0 at v_cnt wrap; adds FB_W after each odd active line (v_cnt[0]=1, v_cnt < V_ACTIVE, at h_cnt = H_TOTAL-1).
  - Stage 1 registers: rd_addr <= line_base + (h_cnt>>1); rd_en <= active.
  - When not active, rd_addr holds its last value and rd_en = 0.
- Pipeline:
  - hs_raw, vs_raw, active and first-pixel flags are delayed through a shift register of depth RD_LATENCY+1.
  - Output stage registers them together with rd_data.
  - Total latency from counter state to pins is L = RD_LATENCY+2 clocks; all outputs stay mutually aligned.
- Outputs:
  - hsync = hs_delayed ? SYNC_POL : ~SYNC_POL; vsync likewise.
  - de = active_delayed.
  - RGB forced to 0 whenever de = 0, regardless of rd_data.
- Address bounds: rd_addr never exceeds FB_W*FB_H-1 (76799); the last active pixel (639,479) reads 76799.
- Reset, asynchronous with rst_n low:
  - h_cnt, v_cnt, line_base, rd_addr, all pipeline stages = 0.
  - rd_en = 0, de = 0, red/green/blue = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - After release, timing restarts at h=0, v=0; the first visible pixel reaches the pins L clocks after the first rising edge with rst_n high.
- Reset mid-frame: the partial frame is abandoned immediately; no residual pulses or stale pixels are emitted.
- No handshake/backpressure: the frame buffer must return data at fixed latency. A camera write to the same address in the same cycle is the RAM's concern (dual-port, read-old or read-new both acceptable).

Test Plan:
- Reset held 5 clocks, then released:
  - During reset: hsync = vsync = 1, de = 0, RGB = 0, rd_en = 0.
  - After release: first de = 1 at clock L = 3 (RD_LATENCY = 1), with frame_start = 1 for exactly that clock.
- Line 0 address sequence: rd_addr = 0,0,1,1,...,319,319 over 640 rd_en clocks, then rd_en = 0 for 160 clocks.
- Line doubling: lines 0 and 1 each start at rd_addr 0; line 2 starts at 320; line 479 ends at 76799; next frame line 0 restarts at 0.
- Sync timing (SYNC_POL = 0):
  - hsync low for exactly 96 clocks, starting 656 clocks after de rises, period 800.
  - vsync low for exactly 1600 clocks (2 lines) starting at line 490, period 420000 clocks.
- Data path with RAM model returning rd_data = rd_addr[15:0] (RD_LATENCY = 1, then 2):
  - Pixel (2,0) shows red/green/blue = 0/0/1, aligned with de.
  - With rd_data = 16'hFFFF during blanking, outputs stay 0.
- rst_n pulsed low at v = 200, h = 300:
  - Outputs return to reset values asynchronously.
  - Next frame_start occurs exactly L clocks after release, with rd_addr = 0.

Source files
------------

// File: rtl/vga_frame_reader.sv
// VGA frame reader: scans a FB_W x FB_H RGB565 frame buffer out as
// 640x480@60 VGA timing, doubling each buffer pixel horizontally and
// vertically. Sync, data-enable, frame_start and RGB are all delayed
// by the same number of clocks so they reach the pins together with the
// frame buffer read data.
module vga_frame_reader #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter int   FB_W       = 320,
  parameter int   FB_H       = 240,
  parameter int   RD_LATENCY = 1,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] rd_addr,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  // Flag pipeline spans the address register plus the RAM read latency.
  localparam int DEPTH   = RD_LATENCY + 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [16:0] FB_STEP        = 17'(FB_W);
  // Base address of the last buffer line; line_base never moves past it,
  // which keeps every generated address inside the buffer.
  localparam logic [16:0] LAST_LINE_BASE = 17'((FB_H - 1) * FB_W);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } flags_t;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [16:0]    line_base;
  flags_t         cur;
  flags_t         pipe [DEPTH];
  flags_t         tap;

  // Stage 0: decode the raw timing flags from the counters.
  always_comb begin
    cur.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    cur.hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    cur.vs     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    cur.first  = (h_cnt == '0) && (v_cnt == '0);
    tap        = pipe[DEPTH-1];
  end

  // Raster counters and the incremental line base address (no multiplier).
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        line_base <= '0;
      end else begin
        v_cnt <= v_cnt + V_W'(1);
        // Each buffer line covers two screen lines: advance after the odd one.
        if (v_cnt[0] && (v_cnt < V_ACT) && (line_base != LAST_LINE_BASE))
          line_base <= line_base + FB_STEP;
      end
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Stage 1: issue the frame buffer read; the address holds during blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
    end else begin
      rd_en <= cur.active;
      if (cur.active)
        rd_addr <= line_base + 17'(h_cnt >> 1);
    end
  end

  // Delay the timing flags to match the address register plus RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this register array is reset explicitly so that no stale sync or
    // enable pulses leak out after a mid-frame reset; it is not a RAM.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Output stage: register pins together with the returned pixel word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hsync       <= tap.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= tap.vs ? SYNC_POL : ~SYNC_POL;
      de          <= tap.active;
      frame_start <= tap.first;
      red         <= tap.active ? rd_data[15:11] : '0;
      green       <= tap.active ? rd_data[10:5]  : '0;
      blue        <= tap.active ? rd_data[4:0]   : '0;
    end
  end

endmodule
